// File: rtl/lc3_mem_arbiter.sv
// Single-port memory arbiter for the LC3 pipeline: shares one variable-latency memory
// between instruction fetch and data access. Data has priority, fetch has a starvation guard, and each access has a timeout.
module lc3_mem_arbiter #(
   parameter int          MAX_DATA_STREAK = 4,
   parameter int          TIMEOUT_CYCLES  = 64,
   parameter logic [15:0] BASE_ADDR       = 16'h3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instrmem_rd,
   input  logic [15:0] pc,
   output logic [15:0] Instr_dout,
   output logic        complete_instr,
   input  logic        data_req,
   input  logic        Data_rd,
   input  logic [15:0] Data_addr,
   input  logic [15:0] Data_din,
   output logic [15:0] Data_dout,
   output logic        complete_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        timeout_err
);

   localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
   localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
   localparam logic [TW-1:0] TLAST      = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [15:0]   mem_addr_q, mem_addr_d;
   logic [15:0]   mem_wdata_q, mem_wdata_d;
   logic [15:0]   instr_dout_q, instr_dout_d;
   logic [15:0]   data_dout_q, data_dout_d;
   logic          cmp_i_q, cmp_i_d;
   logic          cmp_d_q, cmp_d_d;
   logic          tmo_q, tmo_d;
   logic          fin, expired;
   logic [15:0]   rd_val;

   always_comb begin
      state_d      = state_q;
      streak_d     = streak_q;
      tcnt_d       = tcnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      instr_dout_d = instr_dout_q;
      data_dout_d  = data_dout_q;
      cmp_i_d      = 1'b0;
      cmp_d_d      = 1'b0;
      tmo_d        = 1'b0;
      fin          = 1'b0;
      expired      = 1'b0;
      rd_val       = mem_rdata;

      case (state_q)
         IDLE: begin
            // Skip sampling in the completion cycle so a still-held request is not re-served.
            if (!cmp_i_q && !cmp_d_q) begin
               if (data_req && (!instrmem_rd || streak_q < STREAK_MAX)) begin
                  state_d     = DATA;
                  mem_req_d   = 1'b1;
                  mem_addr_d  = Data_addr;
                  mem_we_d    = !Data_rd;
                  mem_wdata_d = Data_din;
                  tcnt_d      = '0;
                  if (!instrmem_rd)
                     streak_d = '0;
                  else if (streak_q != STREAK_MAX)
                     streak_d = streak_q + SW'(1);
               end else if (instrmem_rd) begin
                  state_d    = INSTR;
                  mem_req_d  = 1'b1;
                  mem_addr_d = pc;
                  mem_we_d   = 1'b0;
                  tcnt_d     = '0;
                  streak_d   = '0;
               end
            end
         end
         INSTR, DATA: begin
            if (mem_ack) begin
               fin = 1'b1;
            end else if (TIMEOUT_CYCLES > 0 && tcnt_q == TLAST) begin
               fin     = 1'b1;
               expired = 1'b1;
               rd_val  = 16'h0000;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
            if (fin) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               mem_addr_d = BASE_ADDR;
               tcnt_d     = '0;
               tmo_d      = expired;
               if (state_q == INSTR) begin
                  cmp_i_d      = 1'b1;
                  instr_dout_d = rd_val;
               end else begin
                  cmp_d_d = 1'b1;
                  if (!mem_we_q)
                     data_dout_d = rd_val;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         streak_q     <= '0;
         tcnt_q       <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= BASE_ADDR;
         mem_wdata_q  <= 16'h0000;
         instr_dout_q <= 16'h0000;
         data_dout_q  <= 16'h0000;
         cmp_i_q      <= 1'b0;
         cmp_d_q      <= 1'b0;
         tmo_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         streak_q     <= streak_d;
         tcnt_q       <= tcnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         instr_dout_q <= instr_dout_d;
         data_dout_q  <= data_dout_d;
         cmp_i_q      <= cmp_i_d;
         cmp_d_q      <= cmp_d_d;
         tmo_q        <= tmo_d;
      end
   end

   assign mem_req        = mem_req_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign Instr_dout     = instr_dout_q;
   assign Data_dout      = data_dout_q;
   assign complete_instr = cmp_i_q;
   assign complete_data  = cmp_d_q;
   assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant policy, latency and read data.
module tb_lc3_mem_arbiter;

   localparam int MAXS = 4;
   localparam int TO   = 8;

   logic        clk;
   logic        reset;
   logic        instrmem_rd, data_req, Data_rd, mem_ack;
   logic [15:0] pc, Data_addr, Data_din, mem_rdata;
   logic [15:0] Instr_dout, Data_dout, mem_addr, mem_wdata;
   logic        complete_instr, complete_data, mem_req, mem_we, timeout_err;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] m_instr, m_data;
   int          m_streak;
   logic        exp_d, exp_we;
   logic [15:0] exp_addr, exp_wdata, rise_addr;

   lc3_mem_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TO), .BASE_ADDR(16'h3000)) dut (
      .clk(clk), .reset(reset),
      .instrmem_rd(instrmem_rd), .pc(pc), .Instr_dout(Instr_dout), .complete_instr(complete_instr),
      .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
      .Data_dout(Data_dout), .complete_data(complete_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Policy model: data wins unless fetch is waiting and data already took MAXS grants in a row.
   task automatic predict();
      exp_d = data_req && (!instrmem_rd || m_streak < MAXS);
      if (exp_d) begin
         m_streak  = instrmem_rd ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
         exp_addr  = Data_addr;
         exp_we    = !Data_rd;
         exp_wdata = Data_din;
      end else begin
         m_streak  = 0;
         exp_addr  = pc;
         exp_we    = 1'b0;
         exp_wdata = 16'h0000;
      end
   endtask

   // lat = cycle of mem_req in which the memory acks (1..TO); anything else never acks.
   task automatic run_access(input int lat, input logic [15:0] rv);
      bit to;
      predict();
      step();
      rise_addr = mem_addr;
      chk("req_rise", {15'd0, mem_req}, 16'd1);
      chk("addr", mem_addr, exp_addr);
      chk("we", {15'd0, mem_we}, {15'd0, exp_we});
      if (exp_we) chk("wdata", mem_wdata, exp_wdata);
      to = 1'b1;
      for (int c = 1; c <= TO; c++) begin
         if (c == lat) begin
            mem_ack   = 1'b1;
            mem_rdata = rv;
         end
         step();
         mem_ack = 1'b0;
         if (c == lat) begin
            to = 1'b0;
            break;
         end
         if (c < TO) begin
            chk("req_hold", {15'd0, mem_req}, 16'd1);
            chk("addr_hold", mem_addr, exp_addr);
            chk("no_cmp", {14'd0, complete_instr, complete_data}, 16'd0);
         end
      end
      if (!exp_d) m_instr = to ? 16'h0000 : rv;
      else if (!exp_we) m_data = to ? 16'h0000 : rv;
      chk("req_drop", {15'd0, mem_req}, 16'd0);
      chk("cmp_instr", {15'd0, complete_instr}, {15'd0, !exp_d});
      chk("cmp_data", {15'd0, complete_data}, {15'd0, exp_d});
      chk("timeout_err", {15'd0, timeout_err}, {15'd0, to});
      chk("instr_dout", Instr_dout, m_instr);
      chk("data_dout", Data_dout, m_data);
   endtask

   task automatic turnaround();
      step();
      chk("ta_cmp", {13'd0, complete_instr, complete_data, timeout_err}, 16'd0);
      chk("ta_req", {15'd0, mem_req}, 16'd0);
   endtask

   initial begin
      int ord [10];
      ord = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      reset = 1'b1; instrmem_rd = 1'b0; data_req = 1'b0; Data_rd = 1'b0; mem_ack = 1'b0;
      pc = 16'h0; Data_addr = 16'h0; Data_din = 16'h0; mem_rdata = 16'h0;
      m_instr = 16'h0; m_data = 16'h0; m_streak = 0;
      step(); step();
      chk("rst_addr", mem_addr, 16'h3000);
      chk("rst_ctl", {12'd0, mem_req, mem_we, complete_instr, complete_data}, 16'd0);
      chk("rst_dout", Instr_dout | Data_dout | mem_wdata, 16'd0);
      chk("rst_tmo", {15'd0, timeout_err}, 16'd0);

      reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
      step(); mem_ack = 1'b0;
      chk("idle_ack", {13'd0, mem_req, complete_instr, complete_data}, 16'd0);
      chk("idle_ack_dout", Instr_dout, 16'h0000);

      // single fetch, ack in first mem_req cycle
      instrmem_rd = 1'b1; pc = 16'h3000;
      run_access(1, 16'h1261);
      chk("fetch_val", Instr_dout, 16'h1261);
      instrmem_rd = 1'b0; turnaround();

      // write then read back
      data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4000; Data_din = 16'hBEEF;
      run_access(2, 16'hDEAD);
      data_req = 1'b0; turnaround();
      data_req = 1'b1; Data_rd = 1'b1;
      run_access(3, 16'hBEEF);
      chk("read_val", Data_dout, 16'hBEEF);
      data_req = 1'b0; turnaround();

      // both held: D,D,D,D,I repeating
      instrmem_rd = 1'b1; pc = 16'h3100; data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h5000;
      for (int i = 0; i < 10; i++) begin
         run_access(1, 16'($urandom));
         chk("order", {15'd0, rise_addr == 16'h5000}, 16'(ord[i]));
         turnaround();
      end
      instrmem_rd = 1'b0; data_req = 1'b0;

      // data read never acked, then a normal fetch
      data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4444;
      run_access(0, 16'h1234);
      chk("tmo_val", Data_dout, 16'h0000);
      data_req = 1'b0; turnaround();
      instrmem_rd = 1'b1; pc = 16'h3002;
      run_access(2, 16'h5A5A);
      instrmem_rd = 1'b0; turnaround();

      // ack in the final timeout cycle wins
      instrmem_rd = 1'b1; pc = 16'h3004;
      run_access(TO, 16'h0F0F);
      chk("edge_val", Instr_dout, 16'h0F0F);
      instrmem_rd = 1'b0; turnaround();

      // reset mid-access with fetch waiting
      instrmem_rd = 1'b1; pc = 16'h3200; data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h6000;
      step();
      chk("pre_rst_req", {15'd0, mem_req}, 16'd1);
      chk("pre_rst_addr", mem_addr, 16'h6000);
      step(); step();
      reset = 1'b1;
      step();
      chk("mid_rst_req", {15'd0, mem_req}, 16'd0);
      chk("mid_rst_addr", mem_addr, 16'h3000);
      chk("mid_rst_cmp", {13'd0, complete_instr, complete_data, timeout_err}, 16'd0);
      chk("mid_rst_dout", Instr_dout | Data_dout, 16'd0);
      reset = 1'b0; instrmem_rd = 1'b0; data_req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hAAAA;
      step(); mem_ack = 1'b0;
      chk("late_ack", {13'd0, mem_req, complete_instr, complete_data}, 16'd0);
      step();
      chk("late_ack_cmp", {13'd0, complete_instr, complete_data, timeout_err}, 16'd0);
      chk("late_ack_dout", Data_dout, 16'h0000);
      m_instr = 16'h0; m_data = 16'h0; m_streak = 0;
      instrmem_rd = 1'b1; data_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_access(1, 16'($urandom));
         turnaround();
      end
      instrmem_rd = 1'b0; data_req = 1'b0;
      step();

      // randomized traffic
      for (int it = 0; it < 80; it++) begin
         if (!instrmem_rd && $urandom_range(0, 1) == 1) begin
            instrmem_rd = 1'b1; pc = 16'($urandom);
         end
         if (!data_req && $urandom_range(0, 1) == 1) begin
            data_req = 1'b1; Data_addr = 16'($urandom);
            Data_rd = 1'($urandom_range(0, 1)); Data_din = 16'($urandom);
         end
         if (!instrmem_rd && !data_req) begin
            instrmem_rd = 1'b1; pc = 16'($urandom);
         end
         run_access(int'($urandom_range(0, 9)), 16'($urandom));
         if (exp_d) data_req = 1'b0;
         else instrmem_rd = 1'b0;
         turnaround();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
